debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Synchronises N_CH raw button/switch inputs and debounces both press and release with a symmetric stability counter.
- Emits a level state, one-cycle press and release pulses, and a long-press hold flag per channel.
- Sits between board pins and game control logic; one instance serves all user buttons.

Parameters:
- N_CH, 4, number of independent channels.
- DEBOUNCE_CYCLES, 16777216, consecutive stable cycles required to accept a level change in either direction; must be >= 2.
- HOLD_CYCLES, 50000000, cycles of continuous debounced press before o_hold asserts; 0 disables hold (o_hold tied 0).
- ACTIVE_LOW, {N_CH{1'b0}}, per-channel mask; bit set means that raw input is inverted before synchronisation.
- Derived localparams: CNT_W = clog2(DEBOUNCE_CYCLES); HOLD_W = clog2(HOLD_CYCLES+1).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_btn  input  N_CH  raw asynchronous button inputs.
- o_btn_state  output  N_CH  debounced level; 1 = pressed.
- o_press  output  N_CH  one-cycle pulse on accepted press.
- o_release  output  N_CH  one-cycle pulse on accepted release.
- o_hold  output  N_CH  level; pressed continuously for HOLD_CYCLES.

Behaviour:
- Reset:
  - One clock; reset asynchronous active-high, all state cleared on assertion, no clock needed.
  - Sync flops, counters, o_btn_state, o_press, o_release and o_hold all reset to 0.
- Per channel, fully independent, no cross-channel coupling:
  - Input conditioning: raw = i_btn[c] ^ ACTIVE_LOW[c]; 2-flop synchroniser (s1, s2).
  - Debounce counter cnt[CNT_W-1:0]:
    - If s2 == o_btn_state: cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1: o_btn_state <= s2, cnt <= 0.
    - Else: cnt <= cnt+1.
  - Latency: raw first sampled changed at edge 0 and held stable -> o_btn_state changes at edge DEBOUNCE_CYCLES+1.
  - Glitch rejection: any single cycle where s2 returns to the current state resets cnt to 0; a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
- Pulses:
  - o_press registered high for exactly the one cycle following a 0->1 update of o_btn_state, coincident with o_btn_state first reading 1.
  - o_release does the same on a 1->0 update. Both are 0 at all other times.
  - o_press and o_release are never high together on the same channel.
- Hold counter hcnt[HOLD_W-1:0]:
  - Cleared while o_btn_state == 0.
  - While pressed, increments saturating at HOLD_CYCLES.
  - o_hold = (hcnt == HOLD_CYCLES) registered; asserts HOLD_CYCLES cycles after o_press and stays high until the release is accepted, clearing in the same cycle o_release pulses.
  - Glitches shorter than the debounce window do not clear hold.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap-around; hcnt saturates and does not wrap.
- Reset mid-operation:
  - In-progress counts are discarded and no pulse is emitted.
  - After deassertion, a channel whose input is logically pressed needs a full DEBOUNCE_CYCLES window, then emits o_press.
- Simultaneous events: channels changing on the same edge each update and pulse independently in that cycle.

Decomposition:
- Shared package/header debounce_pkg holds:
  - the clog2 constant function;
  - default constants DEF_DEBOUNCE_CYCLES and DEF_HOLD_CYCLES;
  - a polarity-mask helper constant ALL_ACTIVE_HIGH.
- Sub-module debounce_channel implements one channel: synchroniser, debounce counter, pulse registers and hold counter. Its parameters are DEBOUNCE_CYCLES, HOLD_CYCLES and INVERT.
- debounce_bank is a generate loop instancing N_CH debounce_channel instances.

Test Plan (N_CH=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=4'b1000):
- Clean press: i_btn[0] 0->1 before edge 0, held -> o_btn_state[0]=1 and o_press[0]=1 after edge 5; o_press[0]=0 after edge 6; no other channel toggles.
- Glitch rejection: i_btn[1] high for 3 cycles, low 1, high 3, low -> o_btn_state[1] stays 0 and o_press[1] never pulses.
- Release and hold:
  - Hold ch0 pressed -> o_hold[0]=1 exactly 10 cycles after o_press[0].
  - Drop i_btn[0] -> o_release[0] pulses and o_hold[0] clears 5 edges later, in the same cycle.
  - A 2-cycle low glitch during hold leaves o_hold[0]=1.
- Active-low channel: i_btn[3] held 1 from reset -> o_btn_state[3]=0, no pulses; drive i_btn[3]=0 -> o_press[3] after edge 5.
- Reset mid-count: i_btn[2] high, assert i_rst asynchronously between edges 3 and 4 -> all outputs 0 immediately; after deassert, o_press[2] appears 5 edges later.
- Simultaneous: i_btn[1:0] rise on the same cycle -> o_press=4'b0011 in one cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the button debounce bank.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package debounce_pkg;

    // Default stability window, roughly 0.17 s at 100 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 16777216;

    // Default long-press threshold, 0.5 s at 100 MHz.
    localparam int DEF_HOLD_CYCLES = 50000000;

    // Polarity mask with every channel treated as active-high (no inversion).
    localparam logic [63:0] ALL_ACTIVE_HIGH = '0;

    // Ceiling log2, used to size counters; clog2(1) = 0, clog2(2) = 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop sync, symmetric stability counter, press/release pulses, long-press hold.
// Latency: raw change sampled at edge 0 and held stable shows on o_btn_state at edge DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running, outputs update every cycle.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int   HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter logic INVERT          = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_btn_state,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    // DEBOUNCE_CYCLES must be at least 2, so CNT_W is always >= 1.
    localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
    // A zero hold threshold disables hold; keep a 1-bit counter so widths stay legal.
    localparam bit HOLD_EN = (HOLD_CYCLES > 0);
    localparam int HOLD_W  = HOLD_EN ? clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_EN ? HOLD_W'(HOLD_CYCLES) : '0;

    logic              raw;
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              state_q, state_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              hold_q, hold_d;

    // Fold polarity in before synchronising so all downstream logic sees 1 = pressed.
    assign raw = i_btn ^ INVERT;

    // Synchroniser and debounce counter: a level change is taken only after
    // DEBOUNCE_CYCLES consecutive samples that disagree with the current state;
    // any agreeing sample restarts the window.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (s2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            state_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Edge pulses are registered alongside the state so they line up with
    // the first cycle the new level is visible.
    always_comb begin
        press_d   = state_d & ~state_q;
        release_d = ~state_d & state_q;
    end

    // Hold counter counts cycles spent pressed (saturating). Hold is derived from
    // the next-state values so it rises HOLD_CYCLES after the press pulse and
    // drops in the same cycle as the release pulse.
    always_comb begin
        hcnt_d = hcnt_q;
        if (!state_q) begin
            hcnt_d = '0;
        end else if (hcnt_q != HOLD_MAX) begin
            hcnt_d = hcnt_q + HOLD_W'(1);
        end
        hold_d = HOLD_EN && state_d && (hcnt_d == HOLD_MAX);
    end

    // State registers; reset discards any in-progress count without pulsing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hcnt_q    <= '0;
            hold_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            hcnt_q    <= hcnt_d;
            hold_q    <= hold_d;
        end
    end

    assign o_btn_state = state_q;
    assign o_press     = press_q;
    assign o_release   = release_q;
    assign o_hold      = hold_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounced buttons sharing one clock and reset.
// Latency: per channel, DEBOUNCE_CYCLES+1 edges from first changed sample to o_btn_state.
// Backpressure: none; channels are free-running and uncoupled.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int              N_CH            = 4,
    parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int              HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter logic [N_CH-1:0] ACTIVE_LOW      = N_CH'(ALL_ACTIVE_HIGH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_btn_state,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_hold
);

    // One channel per input bit; the polarity mask bit selects inversion.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .INVERT          (ACTIVE_LOW[c])
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_btn       (i_btn[c]),
            .o_btn_state (o_btn_state[c]),
            .o_press     (o_press[c]),
            .o_release   (o_release[c]),
            .o_hold      (o_hold[c])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank against a window-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_debounce_bank;

    localparam int         N  = 4;
    localparam int         D  = 4;
    localparam int         H  = 10;
    localparam logic [3:0] AL = 4'b1000;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [N-1:0] i_btn;
    logic [N-1:0] o_btn_state;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;
    logic [N-1:0] o_hold;

    debounce_bank #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .ACTIVE_LOW      (AL)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_btn       (i_btn),
        .o_btn_state (o_btn_state),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_hold      (o_hold)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel keeps the logical samples taken at every edge.
    // The value the debouncer judges at an edge is the one sampled two edges earlier;
    // a change is accepted when the last D judged samples all disagree with the state.
    bit           m_hist [N][$];
    logic [N-1:0] m_state, m_press, m_rel, m_hold;
    int           m_edge;
    int           m_press_edge [N];
    logic [N-1:0] al_mask;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_hist[c].delete();
            repeat (D + 2) m_hist[c].push_back(1'b0);
            m_press_edge[c] = 0;
        end
        m_state = '0;
        m_press = '0;
        m_rel   = '0;
        m_hold  = '0;
        m_edge  = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] btn);
        for (int c = 0; c < N; c++) begin
            bit accept;
            m_hist[c].push_back(btn[c] ^ al_mask[c]);
            if (m_hist[c].size() > D + 2) void'(m_hist[c].pop_front());
            // Oldest D entries are the samples judged over the last D edges.
            accept = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (m_hist[c][j] == m_state[c]) accept = 1'b0;
            end
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (accept) begin
                m_state[c] = ~m_state[c];
                if (m_state[c]) begin
                    m_press[c]      = 1'b1;
                    m_press_edge[c] = m_edge;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end
            m_hold[c] = m_state[c] && ((m_edge - m_press_edge[c]) >= H);
        end
        m_edge++;
    endtask

    // Advance one clock with the current inputs and compare all outputs.
    task automatic step();
        model_edge(i_btn);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("state",   32'(o_btn_state), 32'(m_state));
        chk("press",   32'(o_press),     32'(m_press));
        chk("release", 32'(o_release),   32'(m_rel));
        chk("hold",    32'(o_hold),      32'(m_hold));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Asynchronous reset from mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("rst_state",   32'(o_btn_state), 32'h0);
        chk("rst_press",   32'(o_press),     32'h0);
        chk("rst_release", 32'(o_release),   32'h0);
        chk("rst_hold",    32'(o_hold),      32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        al_mask = AL;
        i_rst   = 1'b1;
        i_btn   = 4'b1000;  // every channel logically released
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset_state", 32'(o_btn_state), 32'h0);
        chk("reset_pulse", 32'(o_press | o_release | o_hold), 32'h0);
        i_rst = 1'b0;

        // Idle: active-low channel held high must read released.
        run(8);
        chk("idle_ch3", 32'(o_btn_state), 32'h0);

        // Clean press on ch0: visible after the sixth edge (edge 5).
        i_btn[0] = 1'b1;
        run(5);
        chk("press_early", 32'(o_btn_state), 32'h0);
        step();
        chk("press_state", 32'(o_btn_state), 32'h1);
        chk("press_pulse", 32'(o_press),     32'h1);
        step();
        chk("press_one_cycle", 32'(o_press), 32'h0);

        // Hold rises exactly 10 edges after the press pulse.
        run(8);
        chk("hold_early", 32'(o_hold[0]), 32'h0);
        step();
        chk("hold_on", 32'(o_hold[0]), 32'h1);

        // A 2-cycle low glitch does not disturb state or hold.
        i_btn[0] = 1'b0;
        run(2);
        i_btn[0] = 1'b1;
        run(8);
        chk("hold_glitch", 32'(o_hold[0]), 32'h1);

        // Release: pulse and hold clear land on the same edge.
        i_btn[0] = 1'b0;
        run(5);
        chk("hold_before_rel", 32'(o_hold[0]), 32'h1);
        step();
        chk("rel_pulse", 32'(o_release), 32'h1);
        chk("rel_hold",  32'(o_hold[0]), 32'h0);
        run(3);

        // Glitchy ch1: runs of 3 never reach the 4-sample window.
        i_btn[1] = 1'b1; run(3);
        i_btn[1] = 1'b0; run(1);
        i_btn[1] = 1'b1; run(3);
        i_btn[1] = 1'b0; run(8);
        chk("glitch_ch1", 32'(o_btn_state[1]), 32'h0);

        // Active-low ch3 pressed by driving it low.
        i_btn[3] = 1'b0;
        run(6);
        chk("al_press", 32'(o_press), 32'h8);
        run(2);

        // Reset between edges 3 and 4 of a ch2 count; ch3 still pressed.
        i_btn[2] = 1'b1;
        run(4);
        chk("pre_rst_state", 32'(o_btn_state), 32'h8);
        async_reset();
        run(5);
        chk("post_rst_early", 32'(o_press), 32'h0);
        step();
        chk("post_rst_press", 32'(o_press), 32'hC);

        // Release all, then ch0 and ch1 together.
        i_btn = 4'b1000;
        run(12);
        i_btn[1:0] = 2'b11;
        run(6);
        chk("simul_press", 32'(o_press), 32'h3);
        i_btn = 4'b1000;
        run(12);

        // Random traffic: each channel toggles with probability 1/6 per cycle,
        // occasionally frozen for long stretches so hold can be reached.
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) async_reset();
            if ((k % 250) < 200) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(0, 5) == 0) i_btn[c] = ~i_btn[c];
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
